// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store.
// Data has priority; a wait counter bounds how long a pending fetch can be starved.
module mem_port_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MEM_LAT  = 1,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_enable,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out,
    output logic              busy
);

    localparam int LAT_W  = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [LAT_W-1:0]  LAT_LAST = LAT_W'(MEM_LAT - 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              own_data_q, own_data_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            lat_q      <= '0;
            wait_q     <= '0;
            own_data_q <= 1'b0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            lat_q      <= lat_d;
            wait_q     <= wait_d;
            own_data_q <= own_data_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        lat_d      = lat_q;
        wait_d     = wait_q;
        own_data_d = own_data_q;
        wr_d       = wr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;

        case (state_q)
            S_IDLE: begin
                // Data may only win while the fetch starvation budget is not exhausted.
                if (d_req && (wait_q < WAIT_MAX)) begin
                    own_data_d = 1'b1;
                    wr_d       = d_wr;
                    addr_d     = d_addr;
                    wdata_d    = d_wdata;
                    if (if_req) begin
                        wait_d = wait_q + 1'b1;
                    end
                    lat_d   = '0;
                    state_d = S_ACCESS;
                end else if (if_req) begin
                    own_data_d = 1'b0;
                    wr_d       = 1'b0;
                    addr_d     = if_addr;
                    wdata_d    = '0;
                    wait_d     = '0;
                    lat_d      = '0;
                    state_d    = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (lat_q == LAT_LAST) begin
                    if (!wr_q) begin
                        if (own_data_q) begin
                            d_rdata_d = mem_data_out;
                        end else begin
                            if_rdata_d = mem_data_out;
                        end
                    end
                    lat_d   = '0;
                    state_d = S_DONE;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Write strobe only on the first access cycle so a store commits exactly once.
    assign mem_enable  = (state_q == S_ACCESS);
    assign mem_wr      = (state_q == S_ACCESS) && wr_q && (lat_q == '0);
    assign mem_addr    = addr_q;
    assign mem_data_in = wdata_q;
    assign if_ready    = (state_q == S_DONE) && !own_data_q;
    assign d_ready     = (state_q == S_DONE) && own_data_q;
    assign if_rdata    = if_rdata_q;
    assign d_rdata     = d_rdata_q;
    assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed cases on a MEM_LAT=1/MAX_WAIT=2 and a MEM_LAT=3
// instance, then randomized traffic on the first instance against a transaction-level model.
module tb_mem_port_arbiter;

    localparam int LA  = 1;
    localparam int MWA = 2;
    localparam int LB  = 3;
    localparam int MWB = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_reset, a_if_req, a_if_ready, a_d_req, a_d_wr, a_d_ready;
    logic        a_mem_enable, a_mem_wr, a_busy;
    logic [31:0] a_if_addr, a_if_rdata, a_d_addr, a_d_wdata, a_d_rdata;
    logic [31:0] a_mem_addr, a_mem_data_in, a_mem_data_out;

    logic        b_reset, b_if_req, b_if_ready, b_d_req, b_d_wr, b_d_ready;
    logic        b_mem_enable, b_mem_wr, b_busy;
    logic [31:0] b_if_addr, b_if_rdata, b_d_addr, b_d_wdata, b_d_rdata;
    logic [31:0] b_mem_addr, b_mem_data_in, b_mem_data_out;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LA), .MAX_WAIT(MWA)) u_a (
        .clk(clk), .reset(a_reset),
        .if_req(a_if_req), .if_addr(a_if_addr), .if_ready(a_if_ready), .if_rdata(a_if_rdata),
        .d_req(a_d_req), .d_wr(a_d_wr), .d_addr(a_d_addr), .d_wdata(a_d_wdata),
        .d_ready(a_d_ready), .d_rdata(a_d_rdata),
        .mem_enable(a_mem_enable), .mem_wr(a_mem_wr), .mem_addr(a_mem_addr),
        .mem_data_in(a_mem_data_in), .mem_data_out(a_mem_data_out), .busy(a_busy)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LB), .MAX_WAIT(MWB)) u_b (
        .clk(clk), .reset(b_reset),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_ready(b_if_ready), .if_rdata(b_if_rdata),
        .d_req(b_d_req), .d_wr(b_d_wr), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
        .d_ready(b_d_ready), .d_rdata(b_d_rdata),
        .mem_enable(b_mem_enable), .mem_wr(b_mem_wr), .mem_addr(b_mem_addr),
        .mem_data_in(b_mem_data_in), .mem_data_out(b_mem_data_out), .busy(b_busy)
    );

    // Shared 256-word memory; only instance A writes it, the bench preloads through its own port.
    logic [31:0] bmem [0:255];
    logic        pl_en;
    logic [7:0]  pl_addr;
    logic [31:0] pl_data;

    always @(posedge clk) begin
        if (pl_en) bmem[pl_addr] <= pl_data;
        else if (a_mem_enable && a_mem_wr) bmem[a_mem_addr[7:0]] <= a_mem_data_in;
    end
    assign a_mem_data_out = bmem[a_mem_addr[7:0]];
    assign b_mem_data_out = bmem[b_mem_addr[7:0]];

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [7:0] addr, input logic [31:0] data);
        pl_en   = 1'b1;
        pl_addr = addr;
        pl_data = data;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    // Transaction-level reference model for instance A
    logic [31:0] ref_mem [0:255];
    int          ph;
    bit          m_own_d, m_wr;
    logic [31:0] m_addr, m_wdata, m_ifr, m_dr;
    int          m_wait;

    string order;
    int    first_f;

    initial begin
        a_reset = 1'b1; b_reset = 1'b1; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        a_if_req = 0; a_if_addr = 0; a_d_req = 0; a_d_wr = 0; a_d_addr = 0; a_d_wdata = 0;
        b_if_req = 0; b_if_addr = 0; b_d_req = 0; b_d_wr = 0; b_d_addr = 0; b_d_wdata = 0;
        @(negedge clk);
        for (int i = 0; i < 256; i++) preload(8'(i), $urandom);
        preload(8'h04, 32'h12345678);
        preload(8'h08, 32'hA5A50008);
        preload(8'h50, 32'h0BADF00D);
        preload(8'h60, 32'h600D600D);

        chk1("rst_busy", a_busy, 1'b0);
        chk1("rst_en", a_mem_enable, 1'b0);
        chk1("rst_wr", a_mem_wr, 1'b0);
        chk1("rst_ifrdy", a_if_ready, 1'b0);
        chk1("rst_drdy", a_d_ready, 1'b0);
        chk32("rst_ifrdata", a_if_rdata, 32'h0);
        chk32("rst_drdata", a_d_rdata, 32'h0);
        a_reset = 1'b0; b_reset = 1'b0;

        // Fetch-only read
        a_if_req = 1; a_if_addr = 32'h4;
        @(negedge clk);
        chk1("fetch_en_c1", a_mem_enable, 1'b1);
        chk32("fetch_addr_c1", a_mem_addr, 32'h4);
        chk1("fetch_rdy_c1", a_if_ready, 1'b0);
        @(negedge clk);
        chk1("fetch_rdy_c2", a_if_ready, 1'b1);
        chk32("fetch_rdata_c2", a_if_rdata, 32'h12345678);
        chk1("fetch_drdy_c2", a_d_ready, 1'b0);
        chk1("fetch_en_c2", a_mem_enable, 1'b0);
        a_if_req = 0;
        @(negedge clk);
        chk1("fetch_rdy_c3", a_if_ready, 1'b0);
        chk1("fetch_busy_c3", a_busy, 1'b0);

        // Store then load
        a_d_req = 1; a_d_wr = 1; a_d_addr = 32'h40; a_d_wdata = 32'hDEADBEEF;
        @(negedge clk);
        chk1("st_wr_c1", a_mem_wr, 1'b1);
        chk32("st_addr_c1", a_mem_addr, 32'h40);
        chk32("st_data_c1", a_mem_data_in, 32'hDEADBEEF);
        @(negedge clk);
        chk1("st_rdy_c2", a_d_ready, 1'b1);
        chk1("st_wr_c2", a_mem_wr, 1'b0);
        a_d_wr = 0;
        @(negedge clk);
        chk1("st_busy_c3", a_busy, 1'b0);
        chk32("st_mem", bmem[8'h40], 32'hDEADBEEF);
        @(negedge clk);
        chk1("ld_wr_c4", a_mem_wr, 1'b0);
        @(negedge clk);
        chk1("ld_rdy_c5", a_d_ready, 1'b1);
        chk32("ld_rdata_c5", a_d_rdata, 32'hDEADBEEF);
        a_d_req = 0;
        @(negedge clk);

        // Simultaneous requests: data first, fetch three cycles later
        a_if_req = 1; a_if_addr = 32'h8; a_d_req = 1; a_d_wr = 0; a_d_addr = 32'h40;
        @(negedge clk);
        @(negedge clk);
        chk1("sim_drdy_c2", a_d_ready, 1'b1);
        chk1("sim_ifrdy_c2", a_if_ready, 1'b0);
        chk32("sim_drdata_c2", a_d_rdata, 32'hDEADBEEF);
        a_d_req = 0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk1("sim_ifrdy_c5", a_if_ready, 1'b1);
        chk32("sim_ifrdata_c5", a_if_rdata, 32'hA5A50008);
        chk32("sim_drdata_hold", a_d_rdata, 32'hDEADBEEF);
        a_if_req = 0;
        @(negedge clk);

        // Starvation: both held continuously, MAX_WAIT=2
        a_if_req = 1; a_if_addr = 32'hC; a_d_req = 1; a_d_wr = 0; a_d_addr = 32'h10;
        order = ""; first_f = -1;
        for (int c = 1; c <= 17; c++) begin
            @(negedge clk);
            if (a_d_ready) order = {order, "D"};
            if (a_if_ready) begin
                order = {order, "F"};
                if (first_f < 0) first_f = c;
            end
        end
        a_if_req = 0; a_d_req = 0;
        n_checks++;
        if (order != "DDFDDF") begin
            n_errors++;
            $display("FAIL starve_order: got %s expected DDFDDF", order);
        end
        chk32("starve_first_fetch_cycle", 32'(first_f), 32'd8);
        @(negedge clk);

        // Instance B: single load with MEM_LAT=3
        b_d_req = 1; b_d_wr = 0; b_d_addr = 32'h50;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            chk1("lat3_en", b_mem_enable, 1'b1);
            chk1("lat3_wr", b_mem_wr, 1'b0);
            chk1("lat3_rdy_early", b_d_ready, 1'b0);
        end
        @(negedge clk);
        chk1("lat3_rdy_c4", b_d_ready, 1'b1);
        chk32("lat3_rdata_c4", b_d_rdata, 32'h0BADF00D);
        chk1("lat3_en_c4", b_mem_enable, 1'b0);
        b_d_req = 0;
        @(negedge clk);
        chk1("lat3_busy_c5", b_busy, 1'b0);

        // Instance B: reset in cycle 2 of a fetch
        b_if_req = 1; b_if_addr = 32'h60;
        @(negedge clk);
        @(negedge clk);
        chk1("rstmid_en_c2", b_mem_enable, 1'b1);
        #1 b_reset = 1'b1;
        #1;
        chk1("rstmid_en_now", b_mem_enable, 1'b0);
        chk1("rstmid_busy_now", b_busy, 1'b0);
        chk1("rstmid_rdy_now", b_if_ready, 1'b0);
        b_if_req = 0;
        @(negedge clk);
        chk1("rstmid_rdy_c3", b_if_ready, 1'b0);
        @(negedge clk);
        chk1("rstmid_rdy_c4", b_if_ready, 1'b0);
        chk32("rstmid_rdata", b_if_rdata, 32'h0);
        b_reset = 1'b0;
        b_if_req = 1; b_if_addr = 32'h60;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            chk1("rstmid_refetch_en", b_mem_enable, 1'b1);
            chk1("rstmid_refetch_rdy_early", b_if_ready, 1'b0);
        end
        @(negedge clk);
        chk1("rstmid_refetch_rdy_c4", b_if_ready, 1'b1);
        chk32("rstmid_refetch_rdata", b_if_rdata, 32'h600D600D);
        b_if_req = 0;
        @(negedge clk);

        // Randomized traffic on instance A against the model
        a_reset = 1'b1;
        @(negedge clk);
        a_reset = 1'b0;
        for (int i = 0; i < 256; i++) ref_mem[i] = bmem[i];
        ph = 0; m_own_d = 0; m_wr = 0; m_addr = 0; m_wdata = 0; m_ifr = 0; m_dr = 0; m_wait = 0;

        for (int cyc = 0; cyc < 4000; cyc++) begin
            chk1("rnd_en", a_mem_enable, (ph >= 1 && ph <= LA));
            chk1("rnd_wr", a_mem_wr, (ph == 1 && m_wr));
            chk1("rnd_ifrdy", a_if_ready, (ph == LA + 1 && !m_own_d));
            chk1("rnd_drdy", a_d_ready, (ph == LA + 1 && m_own_d));
            chk1("rnd_busy", a_busy, (ph != 0));
            chk32("rnd_ifrdata", a_if_rdata, m_ifr);
            chk32("rnd_drdata", a_d_rdata, m_dr);
            if (ph >= 1 && ph <= LA) begin
                chk32("rnd_addr", a_mem_addr, m_addr);
                if (m_wr) chk32("rnd_wdata", a_mem_data_in, m_wdata);
            end

            if (!a_if_req || a_if_ready) begin
                a_if_req  = ($urandom_range(0, 2) != 0);
                a_if_addr = $urandom;
            end
            if (!a_d_req || a_d_ready) begin
                a_d_req   = ($urandom_range(0, 3) != 0);
                a_d_wr    = $urandom_range(0, 1) == 1;
                a_d_addr  = $urandom;
                a_d_wdata = $urandom;
            end

            if (ph == 0) begin
                if (a_d_req && m_wait < MWA) begin
                    m_own_d = 1; m_wr = a_d_wr; m_addr = a_d_addr; m_wdata = a_d_wdata;
                    if (a_if_req) m_wait++;
                    if (m_wr) ref_mem[m_addr[7:0]] = m_wdata;
                    ph = 1;
                end else if (a_if_req) begin
                    m_own_d = 0; m_wr = 0; m_addr = a_if_addr;
                    m_wait = 0;
                    ph = 1;
                end
            end else if (ph <= LA) begin
                if (ph == LA && !m_wr) begin
                    if (m_own_d) m_dr = ref_mem[m_addr[7:0]];
                    else m_ifr = ref_mem[m_addr[7:0]];
                end
                ph++;
            end else begin
                ph = 0;
            end
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
